// File: rtl/vga_timing_pkg.sv
// Timing constants and helpers shared by the VGA scan-out block.
//   DEF_*            : 640x480@60 default timing (pixels / lines)
//   R/G/B_MSB/LSB    : RGB565 field positions inside a FIFO element
//   axis_total()     : sum of the four phases of one axis
//   h_total/v_total  : totals for the default timing
//   cnt_width()      : counter width able to hold 0..total-1
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  function automatic int axis_total(input int vis, input int fp, input int sw, input int bp);
    return vis + fp + sw + bp;
  endfunction

  function automatic int h_total();
    return axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  endfunction

  function automatic int v_total();
    return axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
  endfunction

  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_scan_out_if.sv
// Pixel FIFO read interface between pixel_fifo and the scan-out block.
//   fifo_empty   : FIFO has no element
//   fifo_value   : head element (RGB565)
//   fifo_dequeue : pop the head element on this clk edge
// master = FIFO side, slave = consumer (vga_scan_out).
interface vga_scan_out_if #(
  parameter int ELEM_WIDTH = 16
);
  logic                  fifo_empty;
  logic [ELEM_WIDTH-1:0] fifo_value;
  logic                  fifo_dequeue;

  modport master (output fifo_empty, output fifo_value, input fifo_dequeue);
  modport slave  (input fifo_empty, input fifo_value, output fifo_dequeue);
endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis (horizontal or vertical): position counter plus decodes.
//   clk, reset_n : clock, async active-low reset
//   advance      : step the counter this clk
//   count        : current position 0..TOTAL-1
//   active       : count is in the visible region
//   sync_level   : sync pin level for the current position
//   wrap         : count is the last position of the axis
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE  = DEF_H_VISIBLE,
  parameter int FRONT    = DEF_H_FRONT,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BACK     = DEF_H_BACK,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = cnt_width(axis_total(VISIBLE, FRONT, SYNC, BACK))
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          active,
  output logic          sync_level,
  output logic          wrap
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam int CW1   = CW + 1;
  // One extra bit so region bounds equal to TOTAL still fit.
  localparam logic [CW1-1:0] VIS_END    = CW1'(VISIBLE);
  localparam logic [CW1-1:0] SYNC_START = CW1'(VISIBLE + FRONT);
  localparam logic [CW1-1:0] SYNC_END   = CW1'(VISIBLE + FRONT + SYNC);
  localparam logic [CW-1:0]  LAST       = CW'(TOTAL - 1);

  logic [CW-1:0]  count_q, count_d;
  logic [CW1-1:0] count_ext;

  assign count_ext  = {1'b0, count_q};
  assign count      = count_q;
  assign wrap       = (count_q == LAST);
  assign active     = (count_ext < VIS_END);
  assign sync_level = ((count_ext >= SYNC_START) && (count_ext < SYNC_END)) ? SYNC_POL : ~SYNC_POL;

  always_comb begin
    count_d = count_q;
    if (advance) count_d = wrap ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/vga_scan_out.sv
// VGA display back end fed by pixel_fifo. Generates H/V timing, pops one
// RGB565 pixel per visible pixel clock and drives registered 5/6/5 colour,
// hsync and vsync. Flags a sticky underrun when a visible pixel finds the
// FIFO empty and pulses vblank_start when the visible area ends.
//   clk, reset_n     : system clock, async active-low reset
//   fifo             : pixel FIFO read port (slave side)
//   red/green/blue   : registered colour
//   hsync/vsync      : registered sync, aligned with colour
//   vblank_start     : one-clk pulse entering vertical blanking
//   underrun         : sticky empty-in-visible flag
//   clear_underrun   : clears underrun (a simultaneous set wins)
module vga_scan_out
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit SYNC_POL   = 1'b0,
  parameter int ELEM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vga_scan_out_if.slave        fifo,
  output logic [4:0]           red,
  output logic [5:0]           green,
  output logic [4:0]           blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 vblank_start,
  output logic                 underrun,
  input  logic                 clear_underrun
);

  localparam int DW  = cnt_width(CLK_DIV);
  localparam int HCW = cnt_width(axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK));
  localparam int VCW = cnt_width(axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK));

  logic [DW-1:0]         div_q, div_d;
  logic                  pixel_tick;
  logic [HCW-1:0]        h_count;
  logic [VCW-1:0]        v_count;
  logic                  h_active, v_active, h_sync, v_sync, h_wrap;
  logic                  v_wrap_unused;  // vertical counter rolls over on its own
  logic                  active;
  logic [ELEM_WIDTH-1:0] pix;

  logic [4:0] red_q, red_d;
  logic [5:0] green_q, green_d;
  logic [4:0] blue_q, blue_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       vblank_q, vblank_d;
  logic       underrun_q, underrun_d;

  assign pixel_tick = (div_q == DW'(CLK_DIV - 1));
  assign div_d      = pixel_tick ? '0 : div_q + DW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_d;
  end

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_POL(SYNC_POL), .CW(HCW)
  ) u_h_axis (
    .clk(clk), .reset_n(reset_n), .advance(pixel_tick),
    .count(h_count), .active(h_active), .sync_level(h_sync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_POL(SYNC_POL), .CW(VCW)
  ) u_v_axis (
    .clk(clk), .reset_n(reset_n), .advance(pixel_tick & h_wrap),
    .count(v_count), .active(v_active), .sync_level(v_sync), .wrap(v_wrap_unused)
  );

  assign active = h_active & v_active;
  assign pix    = fifo.fifo_value;

  // reset_n in the term keeps the pop low during reset even when CLK_DIV = 1
  // makes pixel_tick permanently high.
  assign fifo.fifo_dequeue = pixel_tick & active & ~fifo.fifo_empty & reset_n;

  always_comb begin
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    vblank_d   = 1'b0;
    underrun_d = underrun_q;
    if (clear_underrun) underrun_d = 1'b0;
    if (pixel_tick) begin
      hsync_d  = h_sync;
      vsync_d  = v_sync;
      // last pixel of the last visible line: counters move to h=0, v=V_VISIBLE
      vblank_d = h_wrap && (v_count == VCW'(V_VISIBLE - 1));
      if (active && !fifo.fifo_empty) begin
        red_d   = pix[R_MSB:R_LSB];
        green_d = pix[G_MSB:G_LSB];
        blue_d  = pix[B_MSB:B_LSB];
      end else begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (active) underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      vblank_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      vblank_q   <= vblank_d;
      underrun_q <= underrun_d;
    end
  end

  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign vblank_start = vblank_q;
  assign underrun     = underrun_q;

endmodule
